seq_alu: RTL and testbench

Parametrised, handshaked successor to the pipeline's combinational ALU. It keeps the existing 4-bit ALUOp encoding and single-cycle logic and arithmetic ops. It adds iterative signed and unsigned multiply and divide with full-width product and remainder outputs, and a signed overflow flag. It sits in the EX stage behind a valid/ready interface, so the hazard unit stalls on `in_ready`/`out_valid` rather than on a fixed latency.

---
 rtl/seq_alu_pkg.sv | 35 +++
 rtl/seq_alu_muldiv.sv | 103 ++++++++++
 rtl/seq_alu.sv | 148 ++++++++++++++
 tb/tb_seq_alu.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared definitions for seq_alu: ALUOp codes, FSM state encoding and op classification.
package seq_alu_pkg;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_MULT  = 4'b1000;
   localparam logic [3:0] OP_DIV   = 4'b1001;
   localparam logic [3:0] OP_MULTU = 4'b1010;
   localparam logic [3:0] OP_DIVU  = 4'b1011;
   localparam logic [3:0] OP_NOR   = 4'b1100;
   localparam logic [3:0] OP_XOR   = 4'b1101;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FIXUP = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic logic is_multicycle(input logic [3:0] op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic is_signed_md(input logic [3:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

   function automatic logic is_div(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative multiply/divide datapath: magnitude shift-add / restoring divide,
// one step per cycle, plus the combinational sign fix-up read out in FIXUP.
module seq_alu_muldiv
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_start,
   input  logic             i_step,
   input  logic [3:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_last,
   output logic [WIDTH-1:0] o_lo,
   output logic [WIDTH-1:0] o_hi
);

   logic             r_is_div;
   logic             r_neg_res;
   logic             r_neg_rem;
   logic             r_div0;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_opnd;

   logic             w_sa;
   logic             w_sb;
   logic [WIDTH-1:0] w_mag_a;
   logic [WIDTH-1:0] w_mag_b;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH-1:0] w_trial;
   logic             w_ge;

   assign w_sa    = is_signed_md(i_op) & i_a[WIDTH-1];
   assign w_sb    = is_signed_md(i_op) & i_b[WIDTH-1];
   assign w_mag_a = w_sa ? -i_a : i_a;
   assign w_mag_b = w_sb ? -i_b : i_b;

   // Multiply: {r_hi,r_lo} starts as {0,|b|}; add |a| on lsb, shift right.
   assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
   // Divide: r_hi is the partial remainder, r_lo shifts dividend out / quotient in.
   assign w_shift = {r_hi, r_lo[WIDTH-1]};
   assign w_ge    = (w_shift >= {1'b0, r_opnd});
   assign w_trial = w_shift[WIDTH-1:0] - r_opnd;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_is_div  <= 1'b0;
         r_neg_res <= 1'b0;
         r_neg_rem <= 1'b0;
         r_div0    <= 1'b0;
         r_cnt     <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_opnd    <= '0;
      end else if (i_start) begin
         r_is_div  <= is_div(i_op);
         r_neg_res <= w_sa ^ w_sb;
         r_neg_rem <= w_sa;
         r_div0    <= (i_b == '0);
         r_cnt     <= '0;
         r_hi      <= '0;
         if (is_div(i_op)) begin
            r_opnd <= w_mag_b;
            r_lo   <= w_mag_a;
         end else begin
            r_opnd <= w_mag_a;
            r_lo   <= w_mag_b;
         end
      end else if (i_step) begin
         r_cnt <= r_cnt + CNT_W'(1);
         if (r_is_div) begin
            r_hi <= w_ge ? w_trial : w_shift[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], w_ge};
         end else begin
            r_hi <= w_sum[WIDTH:1];
            r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
         end
      end
   end

   assign o_last = (r_cnt == CNT_W'(WIDTH - 1));

   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;

   assign w_prod     = {r_hi, r_lo};
   assign w_prod_fix = r_neg_res ? -w_prod : w_prod;
   // Zero divisor yields all-ones quotient; remainder re-signed from |a| gives back a.
   assign w_quo      = r_div0 ? {WIDTH{1'b1}} : (r_neg_res ? -r_lo : r_lo);
   assign w_rem      = r_neg_rem ? -r_hi : r_hi;

   assign o_lo = r_is_div ? w_quo : w_prod_fix[WIDTH-1:0];
   assign o_hi = r_is_div ? w_rem : w_prod_fix[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle logic/arithmetic ops plus iterative mul/div,
// valid/ready on both sides, all outputs registered and held in DONE.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       ALUOp,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALUresult,
   output logic [WIDTH-1:0] hi,
   output logic             zero,
   output logic             overflow
);

   state_t           r_state;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] r_hi_res;
   logic             r_zero;
   logic             r_overflow;

   logic [WIDTH-1:0] w_add;
   logic [WIDTH-1:0] w_sub;
   logic             w_add_ovf;
   logic             w_sub_ovf;
   logic [WIDTH-1:0] w_sc_res;
   logic             w_sc_ovf;
   logic             w_start;
   logic             w_last;
   logic [WIDTH-1:0] w_md_lo;
   logic [WIDTH-1:0] w_md_hi;

   assign w_add     = a + b;
   assign w_sub     = a - b;
   assign w_add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
   assign w_sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);

   always_comb begin
      w_sc_res = '0;
      w_sc_ovf = 1'b0;
      case (ALUOp)
         OP_ADD: begin
            w_sc_res = w_add;
            w_sc_ovf = w_add_ovf;
         end
         OP_SUB: begin
            w_sc_res = w_sub;
            w_sc_ovf = w_sub_ovf;
         end
         OP_AND:  w_sc_res = a & b;
         OP_OR:   w_sc_res = a | b;
         OP_NOR:  w_sc_res = ~(a | b);
         OP_XOR:  w_sc_res = a ^ b;
         // a<b exactly when the wrapped difference sign disagrees with its overflow
         OP_SLT:  w_sc_res = {{(WIDTH-1){1'b0}}, w_sub[WIDTH-1] ^ w_sub_ovf};
         default: w_sc_res = '0;
      endcase
   end

   assign w_start = (r_state == ST_IDLE) && in_valid && is_multicycle(ALUOp);

   seq_alu_muldiv #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_muldiv (
      .clk     (clk),
      .reset_n (reset_n),
      .i_start (w_start),
      .i_step  (r_state == ST_BUSY),
      .i_op    (ALUOp),
      .i_a     (a),
      .i_b     (b),
      .o_last  (w_last),
      .o_lo    (w_md_lo),
      .o_hi    (w_md_hi)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_hi_res    <= '0;
         r_zero      <= 1'b1;
         r_overflow  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_in_ready <= 1'b0;
                  if (is_multicycle(ALUOp)) begin
                     r_state <= ST_BUSY;
                  end else begin
                     r_state     <= ST_DONE;
                     r_out_valid <= 1'b1;
                     r_result    <= w_sc_res;
                     r_hi_res    <= '0;
                     r_zero      <= (w_sc_res == '0);
                     r_overflow  <= w_sc_ovf;
                  end
               end
            end
            ST_BUSY: begin
               if (w_last) begin
                  r_state <= ST_FIXUP;
               end
            end
            ST_FIXUP: begin
               r_state     <= ST_DONE;
               r_out_valid <= 1'b1;
               r_result    <= w_md_lo;
               r_hi_res    <= w_md_hi;
               r_zero      <= (w_md_lo == '0);
               r_overflow  <= 1'b0;
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_state     <= ST_IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign ALUresult = r_result;
   assign hi        = r_hi_res;
   assign zero      = r_zero;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed corner cases, backpressure, mid-op
// reset, then random ops against an arithmetic reference model.
module tb_seq_alu;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    ALUOp;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  ALUresult;
   logic [W-1:0]  hi;
   logic          zero;
   logic          overflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ALUOp     (ALUOp),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ALUresult (ALUresult),
      .hi        (hi),
      .zero      (zero),
      .overflow  (overflow)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference behaviour from plain 64-bit integer arithmetic.
   function automatic void model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] r, output logic [31:0] h,
                                 output logic o, output int lat);
      longint          sx, sy, s;
      longint unsigned ux, uy, p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = 64'(x);
      uy = 64'(y);
      r = '0; h = '0; o = 1'b0; lat = 1;
      case (op)
         4'b0010: begin s = sx + sy; r = s[31:0]; o = (s != longint'($signed(r))); end
         4'b0110: begin s = sx - sy; r = s[31:0]; o = (s != longint'($signed(r))); end
         4'b0000: r = x & y;
         4'b0001: r = x | y;
         4'b1100: r = ~(x | y);
         4'b1101: r = x ^ y;
         4'b0111: r = (sx < sy) ? 32'd1 : 32'd0;
         4'b1000: begin s = sx * sy; {h, r} = s; lat = W + 2; end
         4'b1010: begin p = ux * uy; {h, r} = p; lat = W + 2; end
         4'b1001: begin
            lat = W + 2;
            if (y == 0) begin r = '1; h = x; end
            else begin s = sx / sy; r = s[31:0]; s = sx % sy; h = s[31:0]; end
         end
         4'b1011: begin
            lat = W + 2;
            if (y == 0) begin r = '1; h = x; end
            else begin p = ux / uy; r = p[31:0]; p = ux % uy; h = p[31:0]; end
         end
         default: ;
      endcase
   endfunction

   // Inputs are driven and outputs sampled 1 time unit after a rising edge.
   task automatic run_op(input logic [3:0] op, input logic [31:0] opa, input logic [31:0] opb,
                         input string tag);
      logic [31:0] er, eh;
      logic        eo;
      int          el;
      int          lat;
      bit          seen;
      model(op, opa, opb, er, eh, eo, el);
      chk({tag, ".in_ready_pre"}, in_ready, 1);
      ALUOp = op; a = opa; b = opb; in_valid = 1'b1;
      seen = 0;
      for (lat = 1; lat <= 100; lat++) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         a = $urandom; b = $urandom; ALUOp = 4'($urandom);
         if (out_valid) begin seen = 1; break; end
      end
      if (!seen) lat = 0;
      chk({tag, ".latency"}, lat, el);
      chk({tag, ".result"}, ALUresult, er);
      chk({tag, ".hi"}, hi, eh);
      chk({tag, ".zero"}, zero, (er == 0));
      chk({tag, ".overflow"}, overflow, eo);
      chk({tag, ".in_ready_done"}, in_ready, 0);
      $display("op=%b a=%h b=%h -> result=%h hi=%h zero=%b ovf=%b lat=%0d (%s)",
               op, opa, opb, ALUresult, hi, zero, overflow, lat, tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, ".out_valid_post"}, out_valid, 0);
      chk({tag, ".in_ready_post"}, in_ready, 1);
   endtask

   logic [3:0]  ops [12];
   logic [31:0] corners [6];

   initial begin
      logic [31:0] er, eh, ra, rb, held_r, held_h;
      logic        eo;
      int          el, sel;
      bit          seen;

      ops = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b1101,
              4'b0111, 4'b1000, 4'b1010, 4'b1001, 4'b1011, 4'b0011};
      corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFF9};

      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      ALUOp = '0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset.in_ready", in_ready, 1);
      chk("reset.out_valid", out_valid, 0);
      chk("reset.result", ALUresult, 0);
      chk("reset.hi", hi, 0);
      chk("reset.zero", zero, 1);
      chk("reset.overflow", overflow, 0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      run_op(4'b0010, 32'h7FFFFFFF, 32'h1, "add_ovf");
      run_op(4'b0110, 32'd5, 32'd5, "sub_zero");
      run_op(4'b0110, 32'h80000000, 32'h1, "sub_ovf");
      run_op(4'b0111, 32'hFFFFFFFF, 32'h1, "slt_neg1");
      run_op(4'b0111, 32'h80000000, 32'h1, "slt_minneg");
      run_op(4'b0111, 32'h1, 32'h80000000, "slt_pos");
      run_op(4'b1000, 32'hFFFFFFFD, 32'd7, "mult_neg");
      run_op(4'b1010, 32'hFFFFFFFF, 32'd2, "multu");
      run_op(4'b1001, 32'hFFFFFFF9, 32'd2, "div_neg");
      run_op(4'b1011, 32'd7, 32'd0, "divu_zero");
      run_op(4'b1001, 32'hFFFFFFF9, 32'd0, "div_zero_neg");
      run_op(4'b1001, 32'h80000000, 32'hFFFFFFFF, "div_minneg");
      run_op(4'b0011, 32'h12345678, 32'h9ABCDEF0, "illegal_op");

      // Backpressure: result must hold and a stray request must be ignored.
      model(4'b1101, 32'h0000F0F0, 32'h00FF00FF, er, eh, eo, el);
      ALUOp = 4'b1101; a = 32'h0000F0F0; b = 32'h00FF00FF; in_valid = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         if (out_valid) begin seen = 1; break; end
      end
      chk("bp.out_valid", seen, 1);
      held_r = ALUresult; held_h = hi;
      chk("bp.result", held_r, er);
      for (int i = 0; i < 5; i++) begin
         if (i < 3) begin
            ALUOp = 4'b0010; a = 32'd1; b = 32'd1; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk); #1;
         chk("bp.hold_result", ALUresult, er);
         chk("bp.hold_hi", hi, held_h);
         chk("bp.hold_valid", out_valid, 1);
         chk("bp.hold_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      $display("backpressure xor held result=%h for 5 cycles", ALUresult);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp.release_valid", out_valid, 0);
      @(posedge clk); #1;
      chk("bp.no_stray_valid", out_valid, 0);
      chk("bp.no_stray_ready", in_ready, 1);

      // Reset during the tenth cycle of a multiply.
      ALUOp = 4'b1000; a = 32'hFFFFFFFD; b = 32'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("midreset.busy_ready", in_ready, 0);
      reset_n = 1'b0;
      #1;
      chk("midreset.out_valid", out_valid, 0);
      chk("midreset.in_ready", in_ready, 1);
      chk("midreset.result", ALUresult, 0);
      @(posedge clk); #1;
      chk("midreset.held_ready", in_ready, 1);
      reset_n = 1'b1;
      $display("reset asserted mid-multiply, released");
      @(posedge clk); #1;
      run_op(4'b1000, 32'hFFFFFFFD, 32'd7, "mult_after_reset");

      // Random traffic against the model.
      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 3);
         case (sel)
            0: begin ra = $urandom; rb = $urandom; end
            1: begin ra = 32'($urandom_range(0, 16)) - 32'd8; rb = 32'($urandom_range(0, 16)) - 32'd8; end
            2: begin ra = corners[$urandom_range(0, 5)]; rb = corners[$urandom_range(0, 5)]; end
            default: begin ra = $urandom; rb = 32'd0; end
         endcase
         run_op(ops[$urandom_range(0, 11)], ra, rb, "random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
